// File: rtl/mw_pkg.sv
// Shared defaults and types for the memory-writeback elastic stage.
//   V     : vector result width
//   N     : scalar data width
//   M     : register specifier width
//   LANES : vector lanes (V must divide evenly by LANES)
package mw_pkg;

  localparam int unsigned V     = 128;
  localparam int unsigned N     = 32;
  localparam int unsigned M     = 4;
  localparam int unsigned LANES = 4;

  typedef struct packed {
    logic regw;
    logic regmem;
  } mw_ctrl_t;

endpackage

// File: rtl/mw_slot.sv
// One storage slot of the elastic stage: a payload register plus its valid bit.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low clear of valid and payload
//   ld_i      : load d_i into the payload register
//   d_i       : payload input
//   valid_d_i : next value of the valid bit (updated every cycle)
//   valid_o   : slot holds a live beat
//   q_o       : held payload
module mw_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  input  logic         valid_d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d_i;
      if (ld_i) data_q <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/mwpipe_elastic.sv
// Elastic MEM->WB pipeline stage with a 2-entry (MAIN + SKID) buffer.
// MAIN drives all *_W outputs; SKID absorbs the one beat that arrives while
// MAIN is stalled, so in_ready can come straight from a flop.
//   clk, rst (async active-low), flush (sync squash)
//   in_valid/in_ready   : MEM-side handshake
//   *_M                 : MEM-side payload
//   out_valid/out_ready : WB-side handshake
//   *_W                 : WB-side payload (regw_W/lane_wen_W gated by out_valid)
//   occupancy           : beats currently held (0..2)
module mwpipe_elastic
  import mw_pkg::*;
#(
  parameter int unsigned V     = mw_pkg::V,
  parameter int unsigned N     = mw_pkg::N,
  parameter int unsigned M     = mw_pkg::M,
  parameter int unsigned LANES = mw_pkg::LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             regw_M,
  input  logic             regmem_M,
  input  logic [M-1:0]     regScr_M,
  input  logic [N-1:0]     ALUrslt_M,
  input  logic [N-1:0]     readdata_M,
  input  logic [V-1:0]     regVrslt_M,
  input  logic [LANES-1:0] lane_en_M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             regw_W,
  output logic             regmem_W,
  output logic [M-1:0]     regScr_W,
  output logic [N-1:0]     ALUrslt_W,
  output logic [N-1:0]     readdata_W,
  output logic [V-1:0]     regVrslt_W,
  output logic [LANES-1:0] lane_wen_W,
  output logic [1:0]       occupancy
);

  localparam int unsigned PW = $bits(mw_ctrl_t) + M + 2*N + V + LANES;

  mw_ctrl_t        in_ctrl;
  mw_ctrl_t        main_ctrl;
  logic [LANES-1:0] main_lane_en;
  logic [PW-1:0]   in_pl;
  logic [PW-1:0]   main_pl_d;
  logic [PW-1:0]   main_pl_q;
  logic [PW-1:0]   skid_pl_q;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            main_ld, skid_ld;
  logic            accept, pop;

  assign in_ctrl = '{regw: regw_M, regmem: regmem_M};
  assign in_pl   = {in_ctrl, regScr_M, ALUrslt_M, readdata_M, regVrslt_M, lane_en_M};

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ld      = 1'b0;
    skid_ld      = 1'b0;
    main_pl_d    = in_pl;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        // in_ready is low here, so nothing is accepted this cycle.
        main_ld      = 1'b1;
        main_pl_d    = skid_pl_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_ld      = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_ld      = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  mw_slot #(.W(PW)) u_main (
    .clk       (clk),
    .rst       (rst),
    .ld_i      (main_ld),
    .d_i       (main_pl_d),
    .valid_d_i (main_valid_d),
    .valid_o   (main_valid_q),
    .q_o       (main_pl_q)
  );

  mw_slot #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .ld_i      (skid_ld),
    .d_i       (in_pl),
    .valid_d_i (skid_valid_d),
    .valid_o   (skid_valid_q),
    .q_o       (skid_pl_q)
  );

  assign {main_ctrl, regScr_W, ALUrslt_W, readdata_W, regVrslt_W, main_lane_en} = main_pl_q;

  // Bubbles must never write the register file, whatever stale payload MAIN holds.
  assign regmem_W   = main_ctrl.regmem;
  assign regw_W     = main_ctrl.regw & main_valid_q;
  assign lane_wen_W = main_lane_en & {LANES{main_ctrl.regw & main_valid_q}};
  assign occupancy  = 2'(main_valid_q) + 2'(skid_valid_q);

endmodule
